clkdiv_prog: RTL and testbench
==============================

// Module: clkdiv_prog
// PURPOSE
//   Runtime-programmable clock-enable generator; successor to the fixed half-count divider.
//   Produces an oversample tick, a baud tick every OVERSAMPLE oversample ticks, and a
//   registered ~50% duty square wave at baud rate. Supports glitch-free divisor changes
//   and phase resynchronisation. Drives UART TX/RX baud timing from the single system clock.
// PARAMETERS
//   CNT_W      16   width of divisor and prescale counter
//   OVERSAMPLE 16   os_ticks per baud_tick; power of two, >=2
//   DEF_DIV    27   divisor loaded at reset (clk cycles per os_tick); 2..2**CNT_W-1
// PORTS
//   clk        in   1      system clock
//   rst        in   1      asynchronous reset, active-high
//   en         in   1      count enable; low = freeze all counters and outputs
//   div_val    in   CNT_W  new divisor, sampled when div_load=1
//   div_load   in   1      one-cycle request to load div_val
//   sync       in   1      one-cycle phase realign (e.g. RX start-bit edge)
//   div_pend   out  1      accepted divisor waiting for next os_tick boundary
//   div_err    out  1      one-cycle pulse: div_val<2 on div_load, request dropped
//   os_tick    out  1      one-cycle pulse every div_q clk cycles
//   baud_tick  out  1      one-cycle pulse every div_q*OVERSAMPLE clk cycles
//   clk_div    out  1      square wave, period div_q*OVERSAMPLE cycles
// BEHAVIOUR
//   Reset (async, rst=1): cnt=0, os_cnt=0, div_q=DEF_DIV, stage=0, div_pend=0, div_err=0,
//     os_tick=0, baud_tick=0, clk_div=0. Any pending load is discarded.
//   All outputs are registered. No combinational path from inputs to outputs.
//   Prescaler, on en=1:
//     - cnt counts 0..div_q-1, then wraps to 0.
//     - os_tick=1 in the cycle after the edge where cnt wraps.
//     - With en=1 from reset release, the first os_tick is high after div_q edges.
//   Oversample counter:
//     - os_cnt increments on each wrap, 0..OVERSAMPLE-1, then wraps.
//     - baud_tick=1 together with the os_tick whose wrap took os_cnt to 0.
//     - clk_div registered as (os_cnt_next >= OVERSAMPLE/2): low for first half, high for second.
//   en=0: cnt, os_cnt and clk_div hold; os_tick=0 and baud_tick=0. div_load and sync still act.
//   Divisor load (div_load=1):
//     - div_val<2: div_err pulses next cycle; div_q and stage unchanged.
//     - Otherwise stage<=div_val and div_pend<=1.
//     - A second load while pending overwrites stage (last wins).
//     - A boundary is a prescaler wrap or sync. At a boundary with div_pend=1:
//       div_q<=stage, div_pend<=0.
//     - div_load on the same cycle as a boundary applies div_val directly; div_pend stays 0.
//     - div_q never changes mid-period, so no runt ticks.
//   sync=1: cnt<=0, os_cnt<=0, clk_div<=0, no tick that cycle; has priority over the wrap.
//     Next os_tick comes div_q edges later. Applies a pending divisor. Acts even if en=0.
//   Width: cnt compare is div_q-1 in CNT_W bits; div_q>=2 guaranteed, so no underflow.
// TESTING
//   1. DEF_DIV=4, OVERSAMPLE=4, en=1 after reset -> os_tick every 4 cycles;
//      baud_tick every 16 cycles; clk_div low 8 / high 8.
//   2. Load div_val=6 mid-period -> div_pend=1 until next wrap; prior period stays 4;
//      following periods are 6; div_pend drops at that wrap.
//   3. div_load with div_val=1, then div_val=0 -> div_err pulses each time;
//      period unchanged; div_pend stays 0.
//   4. sync at cnt=2 and os_cnt=3 -> next cycle cnt=0, os_cnt=0, clk_div=0;
//      next os_tick exactly div_q cycles after sync.
//   5. en low for 10 cycles mid-count -> no ticks; counters resume from held values;
//      total period stretched by exactly 10.
//   6. rst pulse with div_pend=1 -> outputs 0 asynchronously; div_q=DEF_DIV; stage discarded.

Source files
------------

// File: rtl/clkdiv_prog.sv
// Programmable clock-enable generator: oversample tick, baud tick and
// baud-rate square wave, with glitch-free divisor reload and phase sync.
module clkdiv_prog #(
  parameter int CNT_W      = 16,
  parameter int OVERSAMPLE = 16,
  parameter int DEF_DIV    = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  input  logic             sync,
  output logic             div_pend,
  output logic             div_err,
  output logic             os_tick,
  output logic             baud_tick,
  output logic             clk_div
);

  localparam int OS_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_HALF = OS_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEF_DIV);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div_q;
  logic [CNT_W-1:0] r_stage;
  logic [OS_W-1:0]  r_os_cnt;
  logic             r_pend;
  logic             r_err;
  logic             r_os_tick;
  logic             r_baud_tick;
  logic             r_clk_div;

  logic             w_wrap;
  logic             w_bound;
  logic             w_load_ok;
  logic             w_os_last;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [OS_W-1:0]  w_os_nxt;

  // sync outranks the prescaler wrap, so a wrap is never seen with sync
  always_comb begin
    w_wrap    = en && !sync && (r_cnt == (r_div_q - CNT_W'(1)));
    w_bound   = w_wrap || sync;
    w_load_ok = div_load && (div_val >= CNT_W'(2));
    w_os_last = (r_os_cnt == OS_LAST);
    w_cnt_nxt = r_cnt;
    w_os_nxt  = r_os_cnt;
    if (sync) begin
      w_cnt_nxt = '0;
      w_os_nxt  = '0;
    end else if (w_wrap) begin
      w_cnt_nxt = '0;
      w_os_nxt  = w_os_last ? '0 : r_os_cnt + OS_W'(1);
    end else if (en) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_os_cnt    <= '0;
      r_os_tick   <= 1'b0;
      r_baud_tick <= 1'b0;
      r_clk_div   <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_os_cnt    <= w_os_nxt;
      r_os_tick   <= w_wrap;
      r_baud_tick <= w_wrap && w_os_last;
      r_clk_div   <= (w_os_nxt >= OS_HALF);
    end
  end

  // divisor only changes at a boundary, so no period is ever cut short
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_q <= DIV_RST;
      r_stage <= '0;
      r_pend  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= div_load && !w_load_ok;
      if (w_bound) begin
        r_pend <= 1'b0;
        if (w_load_ok) begin
          r_div_q <= div_val;
        end else if (r_pend) begin
          r_div_q <= r_stage;
        end
      end else if (w_load_ok) begin
        r_stage <= div_val;
        r_pend  <= 1'b1;
      end
    end
  end

  assign div_pend  = r_pend;
  assign div_err   = r_err;
  assign os_tick   = r_os_tick;
  assign baud_tick = r_baud_tick;
  assign clk_div   = r_clk_div;

endmodule

// File: tb/tb_clkdiv_prog.sv
// Randomised scoreboard bench for clkdiv_prog against a countdown model.
module tb_clkdiv_prog;

  localparam int CNT_W = 8;
  localparam int OS    = 4;
  localparam int DDIV  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic [CNT_W-1:0] div_val = '0;
  logic             div_load = 1'b0;
  logic             sync = 1'b0;
  logic             div_pend, div_err, os_tick, baud_tick, clk_div;

  int checks = 0;
  int errors = 0;

  // expected {os_tick, baud_tick, clk_div, div_pend, div_err}
  logic [4:0] exp_q[$];

  // reference model state
  int m_q, m_stage, m_rem, m_n;
  bit m_pend, m_clk;

  clkdiv_prog #(
    .CNT_W(CNT_W), .OVERSAMPLE(OS), .DEF_DIV(DDIV)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .div_val(div_val),
    .div_load(div_load), .sync(sync), .div_pend(div_pend),
    .div_err(div_err), .os_tick(os_tick), .baud_tick(baud_tick),
    .clk_div(clk_div)
  );

  always #5 clk = ~clk;

  task automatic check1(input string nm, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, req);
    end
  endtask

  task automatic model_reset();
    m_q = DDIV; m_stage = 0; m_rem = DDIV; m_n = 0;
    m_pend = 0; m_clk = 0;
  endtask

  // rem = enabled edges left until the next tick; n = ticks since baud start
  task automatic model_step(input bit e, input bit ld, input int v,
                            input bit s, output logic [4:0] ex);
    bit tick, baud, bound, ok;
    tick = e && !s && (m_rem == 1);
    baud = 0;
    ok = ld && (v >= 2);
    bound = tick || s;
    if (s) begin
      m_n = 0; m_clk = 0;
    end else if (tick) begin
      m_n = (m_n + 1) % OS;
      baud = (m_n == 0);
      m_clk = (m_n >= OS / 2);
    end else if (e) begin
      m_rem--;
    end
    if (bound) begin
      if (ok) m_q = v;
      else if (m_pend) m_q = m_stage;
      m_pend = 0;
      m_rem = m_q;
    end else if (ok) begin
      m_stage = v;
      m_pend = 1;
    end
    ex = {tick, baud, m_clk, m_pend, ld && (v < 2)};
  endtask

  task automatic drive(input bit e, input bit ld, input int v, input bit s);
    logic [4:0] ex;
    en = e; div_load = ld; div_val = CNT_W'(v); sync = s;
    @(posedge clk);
    model_step(e, ld, v, s, ex);
    exp_q.push_back(ex);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0);
  endtask

  // monitor: outputs are presented every cycle; compare after the edge
  initial begin
    logic [4:0] ex;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        check1("os_tick", os_tick, ex[4]);
        check1("baud_tick", baud_tick, ex[3]);
        check1("clk_div", clk_div, ex[2]);
        check1("div_pend", div_pend, ex[1]);
        check1("div_err", div_err, ex[0]);
      end
    end
  end

  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    check1("rst_os_tick", os_tick, 1'b0);
    check1("rst_baud_tick", baud_tick, 1'b0);
    check1("rst_clk_div", clk_div, 1'b0);
    check1("rst_div_pend", div_pend, 1'b0);
    check1("rst_div_err", div_err, 1'b0);
    en = 0; div_load = 0; sync = 0;
    @(negedge clk);
    model_reset();
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    check1("init_os_tick", os_tick, 1'b0);
    check1("init_clk_div", clk_div, 1'b0);
    check1("init_div_pend", div_pend, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idle(40);
    // mid-period load, then invalid loads
    idle(2);
    drive(1, 1, 6, 0);
    idle(30);
    drive(1, 1, 1, 0);
    idle(3);
    drive(1, 1, 0, 0);
    idle(10);
    // en low for 10 cycles
    idle(3);
    for (int i = 0; i < 10; i++) drive(0, 0, 0, 0);
    idle(20);
    // sync mid-count, and sync while disabled with pending load
    idle(2);
    drive(1, 0, 0, 1);
    idle(15);
    drive(1, 1, 3, 0);
    drive(0, 0, 0, 1);
    idle(20);
    // reset while a load is pending
    drive(1, 1, 7, 0);
    do_reset();
    idle(20);
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 9) != 0, ($urandom % 15) == 0,
            int'($urandom_range(0, 9)), ($urandom % 50) == 0);
      if (i == 800) do_reset();
    end
    @(posedge clk);
    #3;
    check1("queue_drained", exp_q.size() == 0, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
